// File: rtl/inst_rom_loader.sv
// Instruction memory with a combinational fetch port and a byte-serial program loader.
// While a load is in progress the core is held and fetches return NOP_INST.
module inst_rom_loader #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned AW          = 12,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    output logic [31:0] ins_o,
    input  logic        ld_start_i,
    input  logic [15:0] ld_words_i,
    input  logic        ld_valid_i,
    input  logic [7:0]  ld_byte_i,
    output logic        ld_ready_o,
    output logic        core_hold_o,
    output logic        ld_done_o,
    output logic        ld_err_o
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH_WORDS);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [AW:0] wr_ptr;
    logic [AW:0] len_q;
    // Holds bytes 0..2 of the word being assembled; byte 3 goes straight to memory.
    logic [23:0] word_shift;
    logic [31:0] mem [DEPTH_WORDS];

    logic accept;
    logic wr_en;
    logic oversize;

    assign accept   = (state == LOAD) && ld_valid_i && ld_ready_o;
    assign wr_en    = accept && (byte_cnt == 2'd3);
    assign oversize = 32'(ld_words_i) > DEPTH_WORDS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            byte_cnt    <= 2'd0;
            wr_ptr      <= '0;
            len_q       <= '0;
            word_shift  <= '0;
            ld_ready_o  <= 1'b0;
            core_hold_o <= 1'b0;
            ld_done_o   <= 1'b0;
            ld_err_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_start_i) begin
                        if (ld_words_i == 16'd0) begin
                            state       <= DONE;
                            ld_done_o   <= 1'b1;
                            core_hold_o <= 1'b1;
                        end else begin
                            state       <= LOAD;
                            ld_ready_o  <= 1'b1;
                            core_hold_o <= 1'b1;
                            len_q       <= oversize ? DEPTH_L : (AW+1)'(ld_words_i);
                            ld_err_o    <= oversize;
                            wr_ptr      <= '0;
                            byte_cnt    <= 2'd0;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        word_shift <= {ld_byte_i, word_shift[23:8]};
                        byte_cnt   <= byte_cnt + 2'd1;
                    end
                    if (wr_en) begin
                        wr_ptr <= wr_ptr + ONE;
                        if (wr_ptr == len_q - ONE) begin
                            state      <= DONE;
                            ld_ready_o <= 1'b0;
                            ld_done_o  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    ld_done_o   <= 1'b0;
                    core_hold_o <= 1'b0;
                    ld_ready_o  <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    ld_done_o   <= 1'b0;
                    core_hold_o <= 1'b0;
                    ld_ready_o  <= 1'b0;
                end
            endcase
        end
    end

    // Array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {ld_byte_i, word_shift};
        end
    end

    always_comb begin
        ins_o = NOP_INST;
        if (state == IDLE && pc_i[1:0] == 2'b00 && pc_i[31:AW+2] == '0) begin
            ins_o = mem[pc_i[AW+1:2]];
        end
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: table-driven fetch checks plus load/reset sequences.
module tb_inst_rom_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = '0;
    logic [31:0] ins_o;
    logic        ld_start_i = 1'b0;
    logic [15:0] ld_words_i = '0;
    logic        ld_valid_i = 1'b0;
    logic [7:0]  ld_byte_i = '0;
    logic        ld_ready_o;
    logic        core_hold_o;
    logic        ld_done_o;
    logic        ld_err_o;

    int checks = 0;
    int errors = 0;

    inst_rom_loader dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .ins_o       (ins_o),
        .ld_start_i  (ld_start_i),
        .ld_words_i  (ld_words_i),
        .ld_valid_i  (ld_valid_i),
        .ld_byte_i   (ld_byte_i),
        .ld_ready_o  (ld_ready_o),
        .core_hold_o (core_hold_o),
        .ld_done_o   (ld_done_o),
        .ld_err_o    (ld_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] exp;
    } fetch_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_chk(input string name, input logic [31:0] pc, input logic [31:0] exp);
        pc_i = pc;
        #1;
        chk(name, ins_o, exp);
    endtask

    task automatic start(input logic [15:0] words);
        ld_start_i = 1'b1;
        ld_words_i = words;
        step();
        ld_start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ld_valid_i = 1'b1;
        ld_byte_i  = b;
        step();
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i) ^ 8'(i >> 8);
    endfunction

    function automatic logic [31:0] pword(input int w);
        return {pat(4*w+3), pat(4*w+2), pat(4*w+1), pat(4*w)};
    endfunction

    initial begin
        fetch_vec_t  fv[6];
        logic [7:0]  img_a[8];
        logic [7:0]  img_g[8];
        logic [7:0]  img_r[8];

        fv[0] = '{"fetch_w0",      32'h0000_0000, 32'h0000_0013};
        fv[1] = '{"fetch_w1",      32'h0000_0004, 32'h0010_0093};
        fv[2] = '{"misalign_2",    32'h0000_0002, NOP};
        fv[3] = '{"misalign_5",    32'h0000_0005, NOP};
        fv[4] = '{"range_4000",    32'h0000_4000, NOP};
        fv[5] = '{"range_8000000", 32'h8000_0000, NOP};

        img_a = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        img_g = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
        img_r = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};

        // Reset state
        step();
        step();
        chk("rst_ready", 32'(ld_ready_o), 0);
        chk("rst_hold",  32'(core_hold_o), 0);
        chk("rst_done",  32'(ld_done_o), 0);
        chk("rst_err",   32'(ld_err_o), 0);
        rst = 1'b0;
        step();

        // Basic load, valid held high
        start(16'd2);
        chk("basic_ready", 32'(ld_ready_o), 1);
        chk("basic_hold",  32'(core_hold_o), 1);
        fetch_chk("load_blocked_pc0", 32'h0, NOP);
        fetch_chk("load_blocked_pc4", 32'h4, NOP);
        for (int i = 0; i < 8; i++) begin
            send_byte(img_a[i]);
            chk("basic_done_timing", 32'(ld_done_o), (i == 7) ? 1 : 0);
        end
        ld_valid_i = 1'b0;
        chk("basic_done_ready", 32'(ld_ready_o), 0);
        chk("basic_done_hold",  32'(core_hold_o), 1);
        step();
        chk("basic_idle_done", 32'(ld_done_o), 0);
        chk("basic_idle_hold", 32'(core_hold_o), 0);
        for (int i = 0; i < 6; i++) fetch_chk(fv[i].name, fv[i].pc, fv[i].exp);

        // Gapped valid
        start(16'd2);
        for (int k = 0; k < 15; k++) begin
            ld_valid_i = (k % 2 == 0);
            ld_byte_i  = img_g[k/2];
            step();
            chk("gap_hold", 32'(core_hold_o), 1);
            chk("gap_done_timing", 32'(ld_done_o), (k == 14) ? 1 : 0);
        end
        ld_valid_i = 1'b0;
        step();
        chk("gap_release", 32'(core_hold_o), 0);
        fetch_chk("gap_w0", 32'h0, 32'hDEAD_BEEF);
        fetch_chk("gap_w1", 32'h4, 32'h1234_5678);

        // Oversize: clamps to 4096 words
        start(16'd5000);
        chk("over_err", 32'(ld_err_o), 1);
        for (int i = 0; i < 16384; i++) begin
            if (i == 16383) begin
                chk("over_ready_last", 32'(ld_ready_o), 1);
                chk("over_nodone_last", 32'(ld_done_o), 0);
            end
            send_byte(pat(i));
        end
        chk("over_done", 32'(ld_done_o), 1);
        chk("over_ready_off", 32'(ld_ready_o), 0);
        ld_byte_i = 8'hFF;
        step();
        ld_valid_i = 1'b0;
        chk("over_idle_hold", 32'(core_hold_o), 0);
        chk("over_err_sticky", 32'(ld_err_o), 1);
        fetch_chk("over_w1",    32'h4, pword(1));
        fetch_chk("over_w4095", 32'h3FFC, pword(4095));

        // Zero length
        ld_valid_i = 1'b1;
        ld_byte_i  = 8'hFF;
        start(16'd0);
        chk("zero_done",  32'(ld_done_o), 1);
        chk("zero_ready", 32'(ld_ready_o), 0);
        chk("zero_hold",  32'(core_hold_o), 1);
        chk("zero_err",   32'(ld_err_o), 1);
        step();
        ld_valid_i = 1'b0;
        chk("zero_done_off", 32'(ld_done_o), 0);
        chk("zero_ready_off", 32'(ld_ready_o), 0);
        fetch_chk("zero_mem_w0", 32'h0, pword(0));

        // Valid-length start clears the error
        start(16'd1);
        chk("clear_err", 32'(ld_err_o), 0);
        for (int i = 0; i < 4; i++) send_byte(img_a[i]);
        ld_valid_i = 1'b0;
        chk("clear_done", 32'(ld_done_o), 1);
        step();
        fetch_chk("clear_w0", 32'h0, 32'h0000_0013);
        fetch_chk("clear_w1_kept", 32'h4, pword(1));

        // Reset mid-load after 6 of 8 bytes
        start(16'd2);
        for (int i = 0; i < 6; i++) send_byte(img_r[i]);
        ld_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(ld_ready_o), 0);
        chk("midrst_hold",  32'(core_hold_o), 0);
        step();
        rst = 1'b0;
        step();
        fetch_chk("midrst_w0", 32'h0, 32'hDDCC_BBAA);
        fetch_chk("midrst_w1", 32'h4, pword(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
